// File: rtl/risc_mem_pkg.sv
// Shared types and defaults for the RISC program memory and its boot loader.
package risc_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

endpackage

// File: rtl/risc_mem_array.sv
// Word storage with one synchronous write port and one asynchronous read port.
module risc_mem_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/risc_prog_mem.sv
// Program/data memory for the RISC core with a checksummed byte-stream boot loader
// that holds the core in reset until a verified image has been written.
module risc_prog_mem
    import risc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    output logic              core_rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_write,
    output logic [DATA_W-1:0] mem_rdata
);

    state_e            state;
    state_e            state_n;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] sum;

    logic              xfer;
    logic              last_byte;
    logic              ld_we;
    logic              core_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign xfer = load_valid && load_ready;

    // len == 0 encodes a full-depth image: wp+1 wraps to 0 on the final byte
    assign last_byte = (ADDR_W'(wp + ADDR_W'(1)) == len);

    always_comb begin
        state_n = state;
        if (load_req) begin
            state_n = ST_LEN;
        end else begin
            case (state)
                ST_LEN:  if (xfer) state_n = ST_DATA;
                ST_DATA: if (xfer && last_byte) state_n = ST_CSUM;
                ST_CSUM: if (xfer) state_n = (load_data == sum) ? ST_RUN : ST_ERR;
                ST_RUN:  state_n = ST_RUN;
                ST_ERR:  state_n = ST_ERR;
                default: state_n = ST_LEN;
            endcase
        end
    end

    // Status outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LEN;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_n;
            core_rst   <= (state_n != ST_RUN);
            load_done  <= (state_n == ST_RUN);
            load_err   <= (state_n == ST_ERR);
            load_ready <= (state_n == ST_LEN) || (state_n == ST_DATA) || (state_n == ST_CSUM);
        end
    end

    // Loader datapath; a transfer coinciding with load_req is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            len <= '0;
            sum <= '0;
        end else if (xfer && !load_req) begin
            case (state)
                ST_LEN: begin
                    len <= load_data[ADDR_W-1:0];
                    wp  <= '0;
                    sum <= '0;
                end
                ST_DATA: begin
                    wp  <= ADDR_W'(wp + ADDR_W'(1));
                    sum <= DATA_W'(sum + load_data);
                end
                default: ;
            endcase
        end
    end

    assign ld_we     = (state == ST_DATA) && xfer && !load_req;
    assign core_we   = (state == ST_RUN) && mem_write;
    assign arr_we    = ld_we || core_we;
    assign arr_waddr = ld_we ? wp : mem_addr;
    assign arr_wdata = ld_we ? load_data : mem_wdata;

    risc_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (mem_addr),
        .rdata (arr_rdata)
    );

    assign mem_rdata = (state == ST_RUN) ? arr_rdata : DATA_W'(0);

endmodule
